// File: rtl/iic_pkg.sv
`timescale 1ns/1ps
// iic_pkg: shared I2C definitions (device address, FSM states)
// used by responder and initiator-side blocks.
package iic_pkg;

    localparam logic [6:0] IIC_DEV_ADDR = 7'h50;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_ACK_DEV,
        ST_REG_HI,
        ST_ACK_HI,
        ST_REG_LO,
        ST_ACK_LO,
        ST_WR_DATA,
        ST_ACK_WR,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } iic_state_e;

    // Each receive state is followed by its own acknowledge state.
    function automatic iic_state_e ack_of(input iic_state_e s);
        iic_state_e r;
        r = ST_IDLE;
        if (s == ST_DEV_ADDR) r = ST_ACK_DEV;
        if (s == ST_REG_HI)   r = ST_ACK_HI;
        if (s == ST_REG_LO)   r = ST_ACK_LO;
        if (s == ST_WR_DATA)  r = ST_ACK_WR;
        return r;
    endfunction

endpackage

// File: rtl/iic_slave_reg_if.sv
`timescale 1ns/1ps
// iic_slave_reg_if: register strobe bus between the I2C responder
// (master side) and the register file (slave side).
interface iic_slave_reg_if;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_wr,
        output reg_rd,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_wr,
        input  reg_rd,
        output reg_rdata
    );
endinterface

// File: rtl/iic_bus_sync.sv
`timescale 1ns/1ps
// iic_bus_sync: scl/sda synchronizers plus edge, START and STOP
// detection in the clk_8m domain.
module iic_bus_sync (
    input  logic clk_8m,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Idle bus level is high, so reset to 1 avoids phantom edges.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign sda_s    = sda_sync[1];
    assign scl_rise = scl_sync[1] & ~scl_d;
    assign scl_fall = ~scl_sync[1] & scl_d;
    assign start    = scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
    assign stop     = scl_sync[1] & scl_d & ~sda_d & sda_sync[1];

endmodule

// File: rtl/iic_slave_reg.sv
`timescale 1ns/1ps
// iic_slave_reg: I2C responder with a 16-bit auto-incrementing
// register pointer driving a one-cycle write/read strobe bus.
module iic_slave_reg
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = IIC_DEV_ADDR
) (
    input  logic            clk_8m,
    input  logic            rst_n,
    input  logic            scl,
    inout  wire             sda,
    iic_slave_reg_if.master bus,
    output logic            busy
);
    iic_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        done_q, done_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        oe_q, oe_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        rd_dly_q;
    logic        busy_q, busy_d;

    logic        scl_rise, scl_fall, sda_s, start, stop;
    logic [7:0]  rx_shift;
    logic        byte_end;

    iic_bus_sync u_sync (
        .clk_8m   (clk_8m),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start    (start),
        .stop     (stop)
    );

    assign rx_shift = {rx_q[6:0], sda_s};
    assign byte_end = scl_rise && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            done_q    <= 1'b0;
            rx_q      <= 8'h00;
            tx_q      <= 8'hFF;
            oe_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            rd_dly_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            rd_dly_q  <= rd_q;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        oe_d      = oe_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        busy_d    = busy_q;

        if (stop) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (start) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = 3'd0;
            done_d    = 1'b0;
            oe_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_DEV_ADDR, ST_REG_HI, ST_REG_LO, ST_WR_DATA: begin
                    if (scl_rise) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        done_d    = byte_end;
                    end else if (scl_fall && done_q) begin
                        done_d  = 1'b0;
                        oe_d    = 1'b1;
                        state_d = ack_of(state_q);
                    end
                    if (byte_end) begin
                        if (state_q == ST_DEV_ADDR) begin
                            if (rx_shift[7:1] == DEV_ADDR) begin
                                busy_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                                busy_d  = 1'b0;
                                done_d  = 1'b0;
                            end
                        end
                        if (state_q == ST_REG_HI) addr_d[15:8] = rx_shift;
                        if (state_q == ST_REG_LO) addr_d[7:0]  = rx_shift;
                        if (state_q == ST_WR_DATA) begin
                            wdata_d = rx_shift;
                            wr_d    = 1'b1;
                        end
                    end
                end
                ST_ACK_DEV: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rx_q[0]) begin
                            // ACK is held until the prefetched byte lands.
                            state_d = ST_RD_DATA;
                            rd_d    = 1'b1;
                        end else begin
                            state_d = ST_REG_HI;
                            oe_d    = 1'b0;
                        end
                    end
                end
                ST_ACK_HI, ST_ACK_LO, ST_ACK_WR: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        oe_d      = 1'b0;
                        state_d   = (state_q == ST_ACK_HI) ? ST_REG_LO : ST_WR_DATA;
                        if (state_q == ST_ACK_WR) addr_d = addr_q + 16'd1;
                    end
                end
                ST_RD_DATA: begin
                    if (rd_dly_q) begin
                        tx_d      = bus.reg_rdata;
                        oe_d      = ~bus.reg_rdata[7];
                        bit_cnt_d = 3'd0;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            done_d  = 1'b0;
                            state_d = ST_RD_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            tx_d      = {tx_q[6:0], 1'b1};
                            oe_d      = ~tx_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            addr_d = addr_q + 16'd1;
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d    = 1'b0;
                        bit_cnt_d = 3'd0;
                        rd_d      = 1'b1;
                        state_d   = ST_RD_DATA;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // Gating with rst_n frees the line without waiting for a clock.
    assign sda = (oe_q && rst_n) ? 1'b0 : 1'bz;

    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_rd    = rd_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_iic_slave_reg.sv
`timescale 1ns/1ps
// tb_iic_slave_reg: randomized ~100 kHz I2C initiator with a
// reference model and a strobe scoreboard for iic_slave_reg.
module tb_iic_slave_reg;
    localparam int Q = 2500;

    logic clk_8m = 1'b0;
    logic rst_n  = 1'b0;
    logic scl    = 1'b1;
    logic m_low  = 1'b0;
    wire  sda;
    logic busy;

    int checks = 0;
    int errors = 0;

    iic_slave_reg_if bus ();

    iic_slave_reg #(.DEV_ADDR(7'h50)) dut (
        .clk_8m (clk_8m),
        .rst_n  (rst_n),
        .scl    (scl),
        .sda    (sda),
        .bus    (bus),
        .busy   (busy)
    );

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #62.5 clk_8m = ~clk_8m;

    function automatic logic [7:0] seed_val(input logic [15:0] a);
        return (a == 16'h0010) ? 8'hC3 : (a[7:0] ^ a[15:8] ^ 8'h5C);
    endfunction

    // Register file seen by the DUT: data one cycle after reg_rd.
    logic [7:0] rf [0:65535];
    bit         rf_ok [0:65535];
    logic [7:0] rf_rdata = 8'h00;
    assign bus.reg_rdata = rf_rdata;

    always @(posedge clk_8m) begin
        if (bus.reg_wr) begin
            rf[bus.reg_addr]    <= bus.reg_wdata;
            rf_ok[bus.reg_addr] <= 1'b1;
        end
        if (bus.reg_rd)
            rf_rdata <= rf_ok[bus.reg_addr] ? rf[bus.reg_addr] : seed_val(bus.reg_addr);
    end

    // Reference model: memory contents and the register pointer.
    logic [7:0]  m_mem [logic [15:0]];
    logic [15:0] m_ptr = 16'h0000;

    function automatic logic [7:0] ref_val(input logic [15:0] a);
        if (m_mem.exists(a)) return m_mem[a];
        return seed_val(a);
    endfunction

    // Expected strobes: {is_wr, addr, data}; data is 0 for reads.
    logic [24:0] exp_q [$];
    logic [24:0] mon_got, mon_want;

    always @(negedge clk_8m) begin
        if (rst_n && (bus.reg_wr || bus.reg_rd)) begin
            mon_got = {bus.reg_wr, bus.reg_addr, bus.reg_wr ? bus.reg_wdata : 8'h00};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: got wr=%0d addr=%h data=%h, expected no strobe",
                         mon_got[24], mon_got[23:8], mon_got[7:0]);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    errors++;
                    $display("FAIL strobe: got wr=%0d addr=%h data=%h, expected wr=%0d addr=%h data=%h",
                             mon_got[24], mon_got[23:8], mon_got[7:0],
                             mon_want[24], mon_want[23:8], mon_want[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic bus_start();
        m_low = 1'b0; #(Q);
        scl   = 1'b1; #(Q);
        m_low = 1'b1; #(Q);
        scl   = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; #(Q);
        scl   = 1'b1; #(Q);
        m_low = 1'b0; #(Q);
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b; #(Q);
        scl   = 1'b1; #(2 * Q);
        scl   = 1'b0; #(Q);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; #(Q);
        scl   = 1'b1; #(Q);
        b     = (sda === 1'b0) ? 1'b0 : 1'b1;
        #(Q);
        scl   = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic last);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(last);
    endtask

    task automatic do_write(input logic [6:0] dev, input logic [15:0] a,
                            input logic [7:0] d [$]);
        logic        ack;
        logic        hit;
        logic [15:0] p;
        hit = (dev == 7'h50);
        if (hit) begin
            p = a;
            foreach (d[i]) begin
                exp_q.push_back({1'b1, p, d[i]});
                m_mem[p] = d[i];
                p = p + 16'd1;
            end
        end
        bus_start();
        write_byte({dev, 1'b0}, ack);
        check("dev_ack", ack, hit);
        if (!hit) begin
            check("busy_unaddressed", busy, 0);
        end else begin
            check("busy_addressed", busy, 1);
            write_byte(a[15:8], ack);
            check("hi_ack", ack, 1);
            write_byte(a[7:0], ack);
            check("lo_ack", ack, 1);
            m_ptr = a;
            foreach (d[i]) begin
                write_byte(d[i], ack);
                check("data_ack", ack, 1);
                m_ptr = m_ptr + 16'd1;
            end
            check("ptr_after_write", bus.reg_addr, m_ptr);
        end
        bus_stop();
        check("busy_after_stop", busy, 0);
    endtask

    task automatic do_ptr_read(input logic [15:0] a, input int n);
        logic       ack;
        logic [7:0] d;
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'b0, 16'(a + 16'(i)), 8'h00});
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(a[15:8], ack);
        write_byte(a[7:0], ack);
        check("ptr_lo_ack", ack, 1);
        m_ptr = a;
        bus_start();
        write_byte(8'hA1, ack);
        check("rd_dev_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(d, (i == n - 1));
            check("rd_data", d, ref_val(m_ptr));
            if (i != n - 1) m_ptr = m_ptr + 16'd1;
        end
        check("sda_after_nack", sda, 1);
        check("busy_after_nack", busy, 0);
        bus_stop();
        check("ptr_after_read", bus.reg_addr, m_ptr);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got no end of stimulus, expected finish before 20 ms");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0]  q [$];
        logic        b;
        logic        ack;
        int          kind;
        int          n;
        logic [15:0] a;
        logic [6:0]  dev;

        repeat (5) @(negedge clk_8m);
        rst_n = 1'b1;
        @(negedge clk_8m);
        check("rst_addr", bus.reg_addr, 16'h0000);
        check("rst_wdata", bus.reg_wdata, 8'h00);
        check("rst_wr", bus.reg_wr, 0);
        check("rst_rd", bus.reg_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_sda", sda, 1);
        #(Q);

        q = {8'h5A};
        do_write(7'h50, 16'h1234, q);
        check("addr_1235", bus.reg_addr, 16'h1235);

        do_ptr_read(16'h0010, 1);

        q = {8'h11, 8'h22};
        do_write(7'h50, 16'hFFFF, q);

        q = {8'h77};
        do_write(7'h51, 16'h4321, q);

        do_ptr_read(16'($urandom), 3);

        // Reset while the responder drives a 0 read bit.
        q = {8'h00};
        do_write(7'h50, 16'h2000, q);
        exp_q.push_back({1'b0, 16'h2000, 8'h00});
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h20, ack);
        write_byte(8'h00, ack);
        bus_start();
        write_byte(8'hA1, ack);
        check("abort_dev_ack", ack, 1);
        for (int i = 0; i < 3; i++) read_bit(b);
        check("abort_bit4_low", sda, 0);
        rst_n = 1'b0;
        #1;
        check("abort_sda_release", sda, 1);
        check("abort_busy", busy, 0);
        repeat (4) @(negedge clk_8m);
        rst_n = 1'b1;
        m_ptr = 16'h0000;
        @(negedge clk_8m);
        check("abort_addr", bus.reg_addr, m_ptr);
        bus_stop();
        q = {8'h3C, 8'hA5};
        do_write(7'h50, 16'h0456, q);

        for (int t = 0; t < 5; t++) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 3);
            a    = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            if (kind == 0) begin
                q.delete();
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                do_write(7'h50, a, q);
            end else if (kind == 1) begin
                do_ptr_read(a, n);
            end else begin
                dev = 7'($urandom);
                if (dev == 7'h50) dev = 7'h2A;
                q = {8'($urandom)};
                do_write(dev, a, q);
            end
        end

        repeat (20) @(negedge clk_8m);
        check("pending_strobes", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iic_slave_reg.md
IIC_SLAVE_REG -- requirements
Module: iic_slave_reg

Interface
REQ-001 SHALL provide parameter DEV_ADDR, default 7'h50, the 7-bit device address this responder answers to.
REQ-002 SHALL provide port clk_8m  input  1  system clock, 8 MHz.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port scl  input  1  bus clock driven by the initiator, asynchronous to clk_8m.
REQ-005 SHALL provide port sda  inout  1  open-drain data line; driven only 1'b0 or released to 'z'.
REQ-006 SHALL provide port reg_addr  output  16  current register address (pointer).
REQ-007 SHALL provide port reg_wdata  output  8  write data, valid while reg_wr is high.
REQ-008 SHALL provide port reg_wr  output  1  one-cycle register write strobe.
REQ-009 SHALL provide port reg_rd  output  1  one-cycle register read strobe.
REQ-010 SHALL provide port reg_rdata  input  8  read data, sampled exactly 1 clk_8m cycle after reg_rd.
REQ-011 SHALL provide port busy  output  1  high from an addressed START until STOP or NACK.

Function
REQ-012 scl and sda inputs SHALL pass through a 2-flop synchronizer followed by 1 edge-detect register, giving a 3-cycle detection latency.
REQ-013 START SHALL be detected as sda falling while scl is high; STOP as sda rising while scl is high.
REQ-014 START, including repeated START, SHALL force state DEV_ADDR from any state and clear the bit counter.
REQ-015 STOP SHALL force state IDLE, release sda, and clear busy from any state.
REQ-016 States SHALL be IDLE, DEV_ADDR, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO, WR_DATA, ACK_WR, RD_DATA, RD_ACK, and WAIT_STOP.
REQ-017 Receive bits SHALL be sampled on synchronized scl rising edges, MSB first; a 3-bit counter SHALL mark byte completion after 8 bits.
REQ-018 In DEV_ADDR, a match of byte[7:1] with DEV_ADDR SHALL go to ACK_DEV; a mismatch SHALL go to WAIT_STOP with sda released and busy low.
REQ-019 ACK SHALL be driven (sda=0) from the scl falling edge after bit 8 until the next scl falling edge.
REQ-020 After ACK_DEV, R/W=0 SHALL go to REG_HI; R/W=1 SHALL go to RD_DATA.
REQ-021 REG_HI then REG_LO SHALL load reg_addr[15:8] and reg_addr[7:0], each acknowledged; after ACK_LO the block SHALL go to WR_DATA.
REQ-022 Each completed WR_DATA byte SHALL set reg_wdata, pulse reg_wr for 1 cycle with the current reg_addr, ACK, then increment reg_addr.
REQ-023 reg_addr SHALL wrap 16'hFFFF to 16'h0000.
REQ-024 On entering RD_DATA, reg_rd SHALL pulse, reg_rdata SHALL load the TX shift register 1 cycle later, and bits SHALL be driven on scl falling edges with 0 driven low and 1 released.
REQ-025 In RD_ACK, the block SHALL sample the initiator bit on scl rising: ACK (0) SHALL increment reg_addr and return to RD_DATA with a new prefetch; NACK (1) SHALL release sda and go to WAIT_STOP.
REQ-026 A read following a repeated START SHALL use the pointer set by the preceding write phase.
REQ-027 sda SHALL never change while synchronized scl is high, except on release at STOP.
REQ-028 When START and STOP are both detected in the same cycle (glitch), STOP SHALL take priority.

Reset
REQ-029 Reset SHALL set state IDLE, sda released, reg_addr=16'h0000, reg_wdata=8'h00, reg_wr=0, reg_rd=0, busy=0, and synchronizer flops=1.
REQ-030 Reset asserted mid-transfer SHALL release sda immediately (asynchronously), and the block SHALL ignore bus traffic until the next START.

Structure
REQ-031 State encodings and the DEV_ADDR default SHALL reside in shared package iic_pkg, also used by the initiator-side blocks.
REQ-032 The synchronizer and START/STOP/edge detector SHALL be sub-module iic_bus_sync.

Verification
REQ-033 Bench SHALL drive the initiator at about 100 kHz scl with a pull-up model on sda.
REQ-034 Write A0 12 34 5A (device 0x50, W) -> ACK on all 4 bytes; reg_wr pulses once with reg_addr=16'h1234 and reg_wdata=8'h5A; reg_addr then equals 16'h1235.
REQ-035 Write A0 00 10, then repeated START, then A1 with reg_rdata model returning 8'hC3 -> read byte equals C3, reg_rd seen with reg_addr=16'h0010, and STOP follows the initiator NACK.
REQ-036 Burst write A0 FF FF 11 22 -> reg_wr seen at addresses 16'hFFFF then 16'h0000 (wrap).
REQ-037 Address 0xA2 -> no ACK (sda stays high at the 9th bit), busy stays 0, and no strobes occur.
REQ-038 Burst read of 3 bytes with ACK, ACK, NACK -> 3 reg_rd pulses at consecutive addresses, and sda released after the NACK.
REQ-039 rst_n low during the RD_DATA bit 4 driven-low phase -> sda goes 'z' within the same cycle; a subsequent A0 transaction completes normally.
